filt_sample_sched: RTL and testbench

//  Sequences the filters datapath. Accepts one XADC sample per sample strobe and latches the sample and the

---
 rtl/filt_pkg.sv | 24 ++
 rtl/filt_wdog.sv | 32 +++
 rtl/filt_sample_sched.sv | 161 ++++++++++++++++
 tb/tb_filt_sample_sched.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/filt_pkg.sv
// Shared constants for the filters sequencer.
// Filter select codes and FSM state encodings.
package filt_pkg;

    localparam logic [1:0] FILT_SEL_LPF     = 2'b00;
    localparam logic [1:0] FILT_SEL_HPF     = 2'b01;
    localparam logic [1:0] FILT_SEL_BPF     = 2'b10;
    localparam logic [1:0] FILT_SEL_INVALID = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        START = 2'b01,
        WAIT  = 2'b10
    } filt_state_t;

    // An invalid request keeps whatever filter was selected before.
    function automatic logic [1:0] next_sel(
        input logic [1:0] cur,
        input logic [1:0] req
    );
        return (req == FILT_SEL_INVALID) ? cur : req;
    endfunction

endpackage

// File: rtl/filt_wdog.sv
// Loadable cycle counter with clear, enable and terminal flag.
// Used both for the start pulse length and for the hang watchdog.
module filt_wdog #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    input  logic [W-1:0] term_val,
    output logic         term
);

    logic [W-1:0] cnt;

    // Counter: clear has priority over load, load over count.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (en)
            cnt <= cnt + 1'b1;
    end

    assign term = en && (cnt == term_val);

endmodule

// File: rtl/filt_sample_sched.sv
// Sample scheduler: latches an XADC sample, starts the filters,
// waits for completion and captures the result; flags overruns/hangs.
module filt_sample_sched
    import filt_pkg::*;
#(
    parameter int XADC_DATA_SIZE  = 16,
    parameter int START_PULSE_LEN = 2,
    parameter int TIMEOUT_CYCLES  = 4096,
    parameter int OVR_CNT_W       = 8
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      en,
    input  logic                      smp_valid,
    input  logic [XADC_DATA_SIZE-1:0] smp_data,
    input  logic [1:0]                sel_req,
    output logic                      filt_start,
    output logic [1:0]                filt_select,
    output logic [XADC_DATA_SIZE-1:0] filt_input,
    input  logic [XADC_DATA_SIZE-1:0] filt_result,
    input  logic                      filt_done,
    output logic                      res_valid,
    output logic [XADC_DATA_SIZE-1:0] res_data,
    output logic [1:0]                res_sel,
    output logic                      busy,
    output logic [OVR_CNT_W-1:0]      ovr_cnt,
    output logic                      timeout_err,
    input  logic                      clr_err
);

    localparam int PW = $clog2(START_PULSE_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    filt_state_t state, state_n;

    logic idle, accept, ovr, go, tmo;
    logic filt_done_d, done_edge, done_pend;
    logic pulse_term, tmo_term;

    assign idle       = (state == IDLE);
    assign busy       = ~idle;
    assign filt_start = (state == START);
    assign accept     = idle & smp_valid & en;
    assign ovr        = smp_valid & busy;
    assign done_edge  = filt_done & ~filt_done_d;

    // Both counters start at 1 on accept so the count equals the
    // number of the current busy cycle.
    filt_wdog #(.W(PW)) u_pulse (
        .clk      (clk),
        .rstn     (rstn),
        .clr      (idle & ~accept),
        .load     (accept),
        .load_val (PW'(1)),
        .en       (filt_start),
        .term_val (PW'(START_PULSE_LEN)),
        .term     (pulse_term)
    );

    filt_wdog #(.W(TW)) u_tmo (
        .clk      (clk),
        .rstn     (rstn),
        .clr      (idle & ~accept),
        .load     (accept),
        .load_val (TW'(1)),
        .en       (busy),
        .term_val (TW'(TIMEOUT_CYCLES - 1)),
        .term     (tmo_term)
    );

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            state <= IDLE;
        else
            state <= state_n;
    end

    // Next state; a completion in the same cycle as the timeout wins.
    always_comb begin
        state_n = state;
        go      = 1'b0;
        tmo     = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept)
                    state_n = START;
            end
            START: begin
                if (tmo_term) begin
                    tmo     = 1'b1;
                    state_n = IDLE;
                end else if (pulse_term) begin
                    state_n = WAIT;
                end
            end
            WAIT: begin
                if (done_edge | done_pend) begin
                    go      = 1'b1;
                    state_n = IDLE;
                end else if (tmo_term) begin
                    tmo     = 1'b1;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Done edge detect; an edge seen during START is held until WAIT.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            filt_done_d <= 1'b0;
            done_pend   <= 1'b0;
        end else begin
            filt_done_d <= filt_done;
            done_pend   <= filt_start & (done_pend | done_edge);
        end
    end

    // Sample and select latch, held for the whole operation.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            filt_input  <= '0;
            filt_select <= FILT_SEL_LPF;
        end else if (accept) begin
            filt_input  <= smp_data;
            filt_select <= next_sel(filt_select, sel_req);
        end
    end

    // Result capture with a one-cycle valid pulse.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            res_valid <= 1'b0;
            res_data  <= '0;
            res_sel   <= FILT_SEL_LPF;
        end else begin
            res_valid <= go;
            if (go) begin
                res_data <= filt_result;
                res_sel  <= filt_select;
            end
        end
    end

    // Error state; a same-cycle event lands after the clear.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ovr_cnt     <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (clr_err)
                ovr_cnt <= OVR_CNT_W'(ovr);
            else if (ovr && !(&ovr_cnt))
                ovr_cnt <= ovr_cnt + 1'b1;
            timeout_err <= (timeout_err & ~clr_err) | tmo;
        end
    end

endmodule

// File: tb/tb_filt_sample_sched.sv
// Self-checking bench for filt_sample_sched.
// Timing expectations are derived arithmetically per operation.
module tb_filt_sample_sched;

    localparam int P  = 2;
    localparam int T  = 64;
    localparam int OW = 2;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        en = 1'b0;
    logic        smp_valid = 1'b0;
    logic [15:0] smp_data = '0;
    logic [1:0]  sel_req = '0;
    logic        filt_start;
    logic [1:0]  filt_select;
    logic [15:0] filt_input;
    logic [15:0] filt_result = '0;
    logic        filt_done = 1'b0;
    logic        res_valid;
    logic [15:0] res_data;
    logic [1:0]  res_sel;
    logic        busy;
    logic [OW-1:0] ovr_cnt;
    logic        timeout_err;
    logic        clr_err = 1'b0;

    int n_cmp = 0;
    int n_fail = 0;

    logic [15:0] exp_input = '0;
    logic [15:0] exp_rd = '0;
    logic [1:0]  exp_sel = '0;
    logic [1:0]  exp_rs = '0;
    int          exp_ovr = 0;
    logic        exp_tmo = 1'b0;

    filt_sample_sched #(
        .XADC_DATA_SIZE  (16),
        .START_PULSE_LEN (P),
        .TIMEOUT_CYCLES  (T),
        .OVR_CNT_W       (OW)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .en          (en),
        .smp_valid   (smp_valid),
        .smp_data    (smp_data),
        .sel_req     (sel_req),
        .filt_start  (filt_start),
        .filt_select (filt_select),
        .filt_input  (filt_input),
        .filt_result (filt_result),
        .filt_done   (filt_done),
        .res_valid   (res_valid),
        .res_data    (res_data),
        .res_sel     (res_sel),
        .busy        (busy),
        .ovr_cnt     (ovr_cnt),
        .timeout_err (timeout_err),
        .clr_err     (clr_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One operation: sample at cycle 0, optional done at done_at
    // (0 = never), overrun strobes at mask bits, clr_err at clr_at.
    task automatic op(input logic [15:0] d, input logic [1:0] s,
                      input logic e, input int done_at,
                      input logic [15:0] r, input logic [63:0] smask,
                      input int clr_at);
        int  rv, last;
        bit  ok, early;
        smp_valid = 1'b1;
        smp_data  = d;
        sel_req   = s;
        en        = e;
        if (!e) begin
            tick();
            smp_valid = 1'b0;
            en        = 1'b1;
            n_cmp++;
            if (busy !== 1'b0 || ovr_cnt !== OW'(exp_ovr)) begin
                n_fail++;
                $display("FAIL en_low busy=%b ovr=%0d want busy=0 ovr=%0d",
                         busy, ovr_cnt, exp_ovr);
            end
            return;
        end
        exp_input = d;
        if (s != 2'b11) exp_sel = s;
        early = (done_at >= 1) && (done_at <= P);
        rv    = early ? P + 2 : done_at + 1;
        ok    = (done_at != 0) && (rv <= T);
        last  = ok ? rv : T;
        for (int k = 1; k <= last; k++) begin
            tick();
            if (k == last) begin
                if (ok) begin
                    exp_rd = r;
                    exp_rs = exp_sel;
                end else begin
                    exp_tmo = 1'b1;
                end
            end
            n_cmp++;
            if (filt_start !== (k <= P)) begin
                n_fail++;
                $display("FAIL start k=%0d got %b want %b",
                         k, filt_start, (k <= P));
            end
            n_cmp++;
            if (busy !== (k < last)) begin
                n_fail++;
                $display("FAIL busy k=%0d got %b want %b", k, busy, (k < last));
            end
            n_cmp++;
            if (filt_input !== exp_input || filt_select !== exp_sel) begin
                n_fail++;
                $display("FAIL latch k=%0d got %h/%0d want %h/%0d",
                         k, filt_input, filt_select, exp_input, exp_sel);
            end
            n_cmp++;
            if (res_valid !== (ok && k == last)) begin
                n_fail++;
                $display("FAIL res_valid k=%0d got %b want %b",
                         k, res_valid, (ok && k == last));
            end
            n_cmp++;
            if (res_data !== exp_rd || res_sel !== exp_rs) begin
                n_fail++;
                $display("FAIL result k=%0d got %h/%0d want %h/%0d",
                         k, res_data, res_sel, exp_rd, exp_rs);
            end
            n_cmp++;
            if (ovr_cnt !== OW'(exp_ovr) || timeout_err !== exp_tmo) begin
                n_fail++;
                $display("FAIL errs k=%0d got ovr=%0d tmo=%b want ovr=%0d tmo=%b",
                         k, ovr_cnt, timeout_err, exp_ovr, exp_tmo);
            end
            if (k < last) begin
                smp_valid = smask[k];
                smp_data  = 16'($urandom);
                sel_req   = 2'($urandom);
                en        = 1'($urandom);
                clr_err   = (k == clr_at);
                if (clr_err) begin
                    exp_ovr = 0;
                    exp_tmo = 1'b0;
                end
                if (smp_valid) exp_ovr = (exp_ovr == 3) ? 3 : exp_ovr + 1;
                filt_done = early ? (k == done_at)
                                  : (done_at != 0 && k >= done_at);
                filt_result = (done_at != 0 && k >= done_at) ? r
                                                             : 16'($urandom);
            end else begin
                smp_valid = 1'b0;
                clr_err   = 1'b0;
                filt_done = 1'b0;
                en        = 1'b1;
            end
        end
    endtask

    task automatic idle_chk(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            n_cmp++;
            if (res_valid !== 1'b0 || busy !== 1'b0 || filt_start !== 1'b0) begin
                n_fail++;
                $display("FAIL idle got rv=%b busy=%b st=%b want 0/0/0",
                         res_valid, busy, filt_start);
            end
        end
    endtask

    task automatic clear_errs();
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        exp_ovr = 0;
        exp_tmo = 1'b0;
        tick();
        n_cmp++;
        if (ovr_cnt !== '0 || timeout_err !== 1'b0) begin
            n_fail++;
            $display("FAIL clr got ovr=%0d tmo=%b want 0/0", ovr_cnt, timeout_err);
        end
    endtask

    task automatic test_reset();
        repeat (3) tick();
        n_cmp++;
        if ({filt_start, filt_select, filt_input, res_valid, res_data,
             res_sel, busy, ovr_cnt, timeout_err} !== 42'd0) begin
            n_fail++;
            $display("FAIL reset_state outputs not all zero, want 0");
        end
        rstn = 1'b1;
        en   = 1'b1;
        idle_chk(2);
    endtask

    task automatic test_nominal();
        op(16'd1234, 2'b00, 1'b1, 40, 16'd777, 64'd0, -1);
        n_cmp++;
        if (res_data !== 16'd777 || res_sel !== 2'b00 || filt_input !== 16'd1234) begin
            n_fail++;
            $display("FAIL nominal got %0d/%0d/%0d want 777/0/1234",
                     res_data, res_sel, filt_input);
        end
        idle_chk(2);
    endtask

    task automatic test_overrun();
        op(16'h0101, 2'b01, 1'b1, 30, 16'h5555, 64'h8420, -1);
        n_cmp++;
        if (ovr_cnt !== 2'd3) begin
            n_fail++;
            $display("FAIL ovr3 got %0d want 3", ovr_cnt);
        end
        op(16'h0202, 2'b10, 1'b1, 25, 16'h6666, 64'h1550, -1);
        n_cmp++;
        if (ovr_cnt !== 2'd3) begin
            n_fail++;
            $display("FAIL ovr_sat got %0d want 3", ovr_cnt);
        end
        clear_errs();
        op(16'h0303, 2'b00, 1'b1, 20, 16'h7777, 64'h1100, 8);
        idle_chk(1);
    endtask

    task automatic test_timeout();
        op(16'h0404, 2'b01, 1'b1, 0, 16'h0, 64'd0, -1);
        n_cmp++;
        if (timeout_err !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout got tmo=%b busy=%b want 1/0", timeout_err, busy);
        end
        idle_chk(2);
        op(16'h0505, 2'b10, 1'b1, 12, 16'h1357, 64'd0, -1);
        idle_chk(1);
        clear_errs();
    endtask

    task automatic test_select();
        op(16'h0606, 2'b10, 1'b1, 9, 16'h2468, 64'h40, -1);
        idle_chk(1);
        op(16'h0707, 2'b11, 1'b1, 10, 16'h1111, 64'd0, -1);
        n_cmp++;
        if (filt_select !== 2'b10 || res_sel !== 2'b10) begin
            n_fail++;
            $display("FAIL sel_keep got %0d/%0d want 2/2", filt_select, res_sel);
        end
        idle_chk(1);
    endtask

    task automatic test_early_done();
        op(16'h0808, 2'b01, 1'b1, 1, 16'h4242, 64'd0, -1);
        idle_chk(3);
        op(16'h0909, 2'b00, 1'b1, 2, 16'h4343, 64'd0, -1);
        idle_chk(3);
    endtask

    task automatic test_en_low();
        op(16'h0a0a, 2'b10, 1'b0, 5, 16'h0, 64'd0, -1);
        idle_chk(2);
        op(16'h0b0b, 2'b01, 1'b1, 7, 16'h9999, 64'd0, -1);
        idle_chk(1);
    endtask

    task automatic test_reset_mid();
        smp_valid = 1'b1;
        smp_data  = 16'hCAFE;
        sel_req   = 2'b01;
        tick();
        smp_valid = 1'b0;
        repeat (10) tick();
        n_cmp++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_busy got %b want 1", busy);
        end
        rstn = 1'b0;
        #1;
        n_cmp++;
        if ({filt_start, filt_select, filt_input, res_valid, res_data,
             res_sel, busy, ovr_cnt, timeout_err} !== 42'd0) begin
            n_fail++;
            $display("FAIL async_reset outputs not all zero, want 0");
        end
        repeat (3) tick();
        rstn = 1'b1;
        exp_input = '0;
        exp_sel   = '0;
        exp_rd    = '0;
        exp_rs    = '0;
        exp_ovr   = 0;
        exp_tmo   = 1'b0;
        tick();
        filt_done   = 1'b1;
        filt_result = 16'hBEEF;
        for (int i = 0; i < 6; i++) begin
            tick();
            n_cmp++;
            if (res_valid !== 1'b0 || busy !== 1'b0 || res_data !== 16'd0) begin
                n_fail++;
                $display("FAIL post_reset got rv=%b busy=%b rd=%h want 0/0/0",
                         res_valid, busy, res_data);
            end
        end
        filt_done = 1'b0;
        tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 25; i++) begin
            int          pick, dn, ca;
            logic [63:0] m;
            pick = $urandom_range(0, 9);
            if (pick == 0)
                dn = 0;
            else if (pick <= 2)
                dn = $urandom_range(1, P);
            else
                dn = $urandom_range(P + 1, 55);
            m  = {$urandom, $urandom} & {$urandom, $urandom};
            ca = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 20) : -1;
            op(16'($urandom), 2'($urandom), ($urandom_range(0, 9) != 0),
               dn, 16'($urandom), m, ca);
            idle_chk($urandom_range(1, 3));
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_overrun();
        test_timeout();
        test_select();
        test_early_done();
        test_en_low();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
